// File: rtl/user_id_readout.sv
// Purpose: settles after reset, captures the 32-bit mask_rev user ID, serves it byte-wise and bit-serially.
// Latency: capture on the SETTLE_CYCLES-th edge after reset release; byte read 1 cycle; serial frame 32 bits (33 with parity).
// Backpressure: none; rd_req is acked every other cycle while held, ser_start outside IDLE is dropped.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, asynchronous active-high reset
//   mask_rev[31:0]            static user ID from the tie-cell block
//   id_valid                  high once the ID has been captured (falls only on reset)
//   rd_req, rd_addr[1:0]      byte read request / byte select (0 = bits 7:0)
//   rd_ack, rd_data[7:0]      single-cycle ack, data held between acks
//   ser_start                 starts a serial dump from IDLE
//   ser_out, ser_valid        serial bit, MSB first, and its qualifier
//   ser_done                  single-cycle pulse after the last frame bit
//   id_parity                 even-parity bit of the ID (only with USER_ID_PARITY_EN)
//
// Optional feature macro: USER_ID_PARITY_EN -- adds id_parity and appends it as a 33rd serial bit.

module user_id_readout #(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] mask_rev,
    output logic        id_valid,
    input  logic        rd_req,
    input  logic [1:0]  rd_addr,
    output logic        rd_ack,
    output logic [7:0]  rd_data,
    input  logic        ser_start,
    output logic        ser_out,
    output logic        ser_valid,
    output logic        ser_done
`ifdef USER_ID_PARITY_EN
    ,
    output logic        id_parity
`endif
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

`ifdef USER_ID_PARITY_EN
    localparam logic [5:0] LAST_BIT = 6'd32;
`else
    localparam logic [5:0] LAST_BIT = 6'd31;
`endif

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        IDLE   = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t      state;
    logic [3:0]  settle_cnt;
    logic [5:0]  bit_cnt;
    logic [31:0] id_reg;
    logic [5:0]  next_cnt;
    logic        next_bit;

    assign next_cnt = bit_cnt + 6'd1;

    // Bit to present after the next shift edge: ID bits MSB first, then parity when enabled.
    always_comb begin
        next_bit = 1'b0;
        if (next_cnt < 6'd32) begin
            next_bit = id_reg[5'd31 - next_cnt[4:0]];
        end
`ifdef USER_ID_PARITY_EN
        else begin
            next_bit = id_parity;
        end
`endif
    end

    // Capture FSM and serial shifter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= SETTLE;
            settle_cnt <= 4'd0;
            bit_cnt    <= 6'd0;
            id_reg     <= 32'd0;
            id_valid   <= 1'b0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            ser_done   <= 1'b0;
`ifdef USER_ID_PARITY_EN
            id_parity  <= 1'b0;
`endif
        end else begin
            case (state)
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        id_reg   <= mask_rev;
                        id_valid <= 1'b1;
`ifdef USER_ID_PARITY_EN
                        id_parity <= ^mask_rev;
`endif
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (ser_start) begin
                        bit_cnt   <= 6'd0;
                        ser_out   <= id_reg[31];
                        ser_valid <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_cnt == LAST_BIT) begin
                        ser_out   <= 1'b0;
                        ser_valid <= 1'b0;
                        ser_done  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bit_cnt <= next_cnt;
                        ser_out <= next_bit;
                    end
                end
                DONE: begin
                    ser_done <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= SETTLE;
            endcase
        end
    end

    // Byte read path: id_reg is static after capture, so this runs alongside the FSM.
    // A request is not re-serviced in its own ack cycle, giving alternate-cycle acks when held.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rd_ack  <= 1'b0;
            rd_data <= 8'd0;
        end else if (id_valid && rd_req && !rd_ack) begin
            rd_ack  <= 1'b1;
            rd_data <= id_reg[{rd_addr, 3'b000} +: 8];
        end else begin
            rd_ack  <= 1'b0;
        end
    end

endmodule
